cordic_quadrant_wrap: RTL and testbench
=======================================

// Module: cordic_quadrant_wrap
// PURPOSE
//  Full-circle sine/cosine front/back stage around the first-quadrant cordic core. Splits a full-circle angle
//  into quadrant + first-quadrant residue, launches the core (rotation mode, x=K, y=0), captures core_x/core_y
//  and folds them into signed cos/sin. Valid/ready on the user side; start/ready/done on the core side.
// PARAMETERS
//  BIT_WIDTH  32              core data/angle width; outputs are BIT_WIDTH+1 two's complement
//  K          32'sd1304052707 CORDIC gain constant driven onto core_x
// PORTS
//  clk        in   1            clock
//  reset      in   1            synchronous, active-low (0 = reset)
//  in_valid   in   1            angle request valid
//  in_ready   out  1            request accepted when in_valid & in_ready
//  in_angle   in   BIT_WIDTH+2  [BW+1:BW] quadrant, [BW-1:0] residue (0..pi/2 scaled as core)
//  out_valid  out  1            result valid, held until out_ready
//  out_ready  in   1            consumer accepts result
//  out_cos    out  BIT_WIDTH+1  signed cosine (+/-(2^BW-1) = +/-1)
//  out_sin    out  BIT_WIDTH+1  signed sine
//  core_start out 1; core_mode out 1 (always 0); core_angle/core_x/core_y out BW (residue, K, 0)
//  core_ready in 1; core_done in 1; core_x_in/core_y_in in BW (unsigned cos/sin of residue)
// BEHAVIOUR
//  Reset (reset==0 at clk edge): state IDLE; in_ready=0 during reset, 1 first cycle after; out_valid=0,
//   out_cos=out_sin=0, core_start=0, captured registers cleared. Reset mid-computation abandons it silently.
//  FSM IDLE -> LAUNCH -> WAIT_LO -> WAIT_HI -> OUT:
//   IDLE: in_ready=1; on in_valid latch quadrant+residue -> LAUNCH.
//   LAUNCH: core_start=1 for exactly one cycle once core_ready=1 (waits otherwise) -> WAIT_LO.
//   WAIT_LO: wait core_done==0 (core has started) -> WAIT_HI. Stale done before launch never captured.
//   WAIT_HI: on core_done==1 register fold result -> OUT.
//   OUT: out_valid=1, outputs stable; in_ready=out_ready. On out_ready: in_valid ? latch -> LAUNCH : IDLE.
//  Fold (c=core_x_in, s=core_y_in, zero-extended to BW+1): q0 cos=c,sin=s; q1 cos=-s,sin=c;
//   q2 cos=-c,sin=-s; q3 cos=s,sin=-c. Negation is two's complement on BW+1 bits; -0 = 0; no saturation needed.
//  Latency in_valid accept -> out_valid = core latency + 3 cycles. core_angle/x/y held constant LAUNCH..WAIT_HI.
//  in_valid while not in_ready: ignored (producer must hold). out_ready while !out_valid: ignored.
// CONFIGURATION
//  CORDIC_QUAD_AXIS_BYPASS_EN defined: residue==0 skips core; IDLE -> OUT next cycle with exact axis values
//   (q0 cos=+MAX,sin=0; q1 cos=0,sin=+MAX; q2 cos=-MAX,sin=0; q3 cos=0,sin=-MAX; MAX=2^BW-1); core_start stays 0.
//  Undefined: every request, including residue 0, goes through the core.
// STRUCTURE
//  cordic_quad_pkg: state_t enum {IDLE,LAUNCH,WAIT_LO,WAIT_HI,OUT}, quad_t enum {Q0..Q3}, default K constant.
//  Sub-module cordic_quad_fold: combinational (quad, c, s) -> (cos, sin); reused by bypass path.
// TESTING (BIT_WIDTH=32, behavioural core stub returning c=0x1234, s=0x5678 after 5 cycles)
//  in_angle={2'b00,32'h4000_0000} -> core_angle=0x4000_0000, one core_start pulse; out_cos=0x0_0000_1234, out_sin=0x0_0000_5678.
//  quadrant 2 -> out_cos=0x1_FFFF_EDCC, out_sin=0x1_FFFF_A988; quadrant 1 -> cos=0x1_FFFF_A988, sin=0x0_0000_1234.
//  out_ready=0 for 10 cycles in OUT -> out_valid/out_cos/out_sin stable; release with in_valid=1 -> back-to-back accept, no idle cycle.
//  core_ready=0 for 4 cycles in LAUNCH, core_done stuck 1 before launch -> start only after core_ready, no early capture.
//  reset=0 asserted in WAIT_HI -> next cycle out_valid=0, outputs 0, state IDLE; later request completes normally.
//  with CORDIC_QUAD_AXIS_BYPASS_EN, in_angle={2'b11,32'h0} -> no core_start, out_valid 1 cycle later, cos=0, sin=0x1_0000_0001.

Source files
------------

// File: rtl/cordic_quad_pkg.sv
// Shared types and constants for the full-circle CORDIC quadrant wrapper.
package cordic_quad_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        OUT     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_t;

    localparam logic signed [31:0] CORDIC_K_DEFAULT = 32'sd1304052707;

endpackage

// File: rtl/cordic_quad_fold.sv
// Folds first-quadrant unsigned cos/sin into signed full-circle cos/sin for a given quadrant.
module cordic_quad_fold
    import cordic_quad_pkg::*;
#(
    parameter int BW = 32
) (
    input  quad_t                quad_i,
    input  logic [BW-1:0]        c_i,
    input  logic [BW-1:0]        s_i,
    output logic signed [BW:0]   cos_o,
    output logic signed [BW:0]   sin_o
);

    logic signed [BW:0] c_ext;
    logic signed [BW:0] s_ext;

    assign c_ext = {1'b0, c_i};
    assign s_ext = {1'b0, s_i};

    // Inputs are at most 2^BW-1, so negation on BW+1 bits never overflows.
    always_comb begin
        cos_o = c_ext;
        sin_o = s_ext;
        case (quad_i)
            Q0: begin cos_o = c_ext;  sin_o = s_ext;  end
            Q1: begin cos_o = -s_ext; sin_o = c_ext;  end
            Q2: begin cos_o = -c_ext; sin_o = -s_ext; end
            Q3: begin cos_o = s_ext;  sin_o = -c_ext; end
            default: begin cos_o = c_ext; sin_o = s_ext; end
        endcase
    end

endmodule

// File: rtl/cordic_quadrant_wrap.sv
// Full-circle sin/cos wrapper around a first-quadrant CORDIC core.
// Optional CORDIC_QUAD_AXIS_BYPASS_EN: zero residue skips the core and returns exact axis values.
module cordic_quadrant_wrap
    import cordic_quad_pkg::*;
#(
    parameter int                        BIT_WIDTH = 32,
    parameter logic signed [BIT_WIDTH-1:0] K       = CORDIC_K_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BIT_WIDTH+1:0]         in_angle,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [BIT_WIDTH:0]    out_cos,
    output logic signed [BIT_WIDTH:0]    out_sin,
    output logic                         core_start,
    output logic                         core_mode,
    output logic [BIT_WIDTH-1:0]         core_angle,
    output logic [BIT_WIDTH-1:0]         core_x,
    output logic [BIT_WIDTH-1:0]         core_y,
    input  logic                         core_ready,
    input  logic                         core_done,
    input  logic [BIT_WIDTH-1:0]         core_x_in,
    input  logic [BIT_WIDTH-1:0]         core_y_in
);

    localparam int BW = BIT_WIDTH;
    localparam logic [BW-1:0] MAX = {BW{1'b1}};

    state_t             state_q, state_d;
    quad_t              quad_q, quad_d;
    logic [BW-1:0]      resid_q, resid_d;
    logic signed [BW:0] cos_q, cos_d;
    logic signed [BW:0] sin_q, sin_d;

    logic               accept;
    logic               bypass;
    quad_t              in_quad;
    logic [BW-1:0]      in_resid;
    quad_t              f_quad;
    logic [BW-1:0]      f_c, f_s;
    logic signed [BW:0] f_cos, f_sin;

    assign in_quad  = quad_t'(in_angle[BW+1:BW]);
    assign in_resid = in_angle[BW-1:0];

    assign in_ready  = reset && ((state_q == IDLE) || ((state_q == OUT) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == OUT);
    assign out_cos   = cos_q;
    assign out_sin   = sin_q;

    assign core_start = reset && (state_q == LAUNCH) && core_ready;
    assign core_mode  = 1'b0;
    assign core_angle = resid_q;
    assign core_x     = K;
    assign core_y     = '0;

`ifdef CORDIC_QUAD_AXIS_BYPASS_EN
    assign bypass = accept && (in_resid == '0);
`else
    assign bypass = 1'b0;
`endif

    // The fold unit serves both the core result and the axis shortcut.
    assign f_quad = bypass ? in_quad : quad_q;
    assign f_c    = bypass ? MAX     : core_x_in;
    assign f_s    = bypass ? '0      : core_y_in;

    cordic_quad_fold #(.BW(BW)) u_fold (
        .quad_i (f_quad),
        .c_i    (f_c),
        .s_i    (f_s),
        .cos_o  (f_cos),
        .sin_o  (f_sin)
    );

    always_comb begin
        state_d = state_q;
        quad_d  = quad_q;
        resid_d = resid_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        case (state_q)
            IDLE, OUT: begin
                if (accept) begin
                    quad_d  = in_quad;
                    resid_d = in_resid;
                    if (bypass) begin
                        cos_d   = f_cos;
                        sin_d   = f_sin;
                        state_d = OUT;
                    end else begin
                        state_d = LAUNCH;
                    end
                end else if ((state_q == OUT) && out_ready) begin
                    state_d = IDLE;
                end
            end
            LAUNCH:  if (core_ready) state_d = WAIT_LO;
            // A done level left over from an earlier run must drop before we trust it.
            WAIT_LO: if (!core_done) state_d = WAIT_HI;
            WAIT_HI: begin
                if (core_done) begin
                    cos_d   = f_cos;
                    sin_d   = f_sin;
                    state_d = OUT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            quad_q  <= Q0;
            resid_q <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
        end else begin
            state_q <= state_d;
            quad_q  <= quad_d;
            resid_q <= resid_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
        end
    end

endmodule

// File: tb/tb_cordic_quadrant_wrap.sv
// Self-checking bench for cordic_quadrant_wrap with a behavioural 5-cycle core stub.
// Covers the CORDIC_QUAD_AXIS_BYPASS_EN build when that macro is defined.
module tb_cordic_quadrant_wrap;

    localparam int BW = 32;
    localparam logic [31:0] KVAL = 32'd1304052707;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW+1:0] in_angle = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW:0]   out_cos, out_sin;
    logic          core_start, core_mode;
    logic [BW-1:0] core_angle, core_x, core_y;
    logic          core_ready, core_done;
    logic [BW-1:0] core_x_in, core_y_in;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cordic_quadrant_wrap #(.BIT_WIDTH(BW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_angle(in_angle),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cos(out_cos), .out_sin(out_sin),
        .core_start(core_start), .core_mode(core_mode),
        .core_angle(core_angle), .core_x(core_x), .core_y(core_y),
        .core_ready(core_ready), .core_done(core_done),
        .core_x_in(core_x_in), .core_y_in(core_y_in)
    );

    // Core stub: busy for 5 cycles after a start, then holds done and results.
    logic        stub_busy = 1'b0, stub_done = 1'b0;
    logic        ready_block = 1'b0, done_force = 1'b0;
    int          stub_cnt = 0, start_cnt = 0;
    logic [31:0] stub_x = '0, stub_y = '0, nxt_c = '0, nxt_s = '0;

    assign core_ready = ~stub_busy & ~ready_block;
    assign core_done  = stub_done | done_force;
    assign core_x_in  = stub_x;
    assign core_y_in  = stub_y;

    always @(posedge clk) begin
        if (core_start && core_ready) begin
            stub_busy <= 1'b1;
            stub_done <= 1'b0;
            stub_cnt  <= 5;
            start_cnt <= start_cnt + 1;
        end else if (stub_busy) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                stub_busy <= 1'b0;
                stub_done <= 1'b1;
                stub_x    <= nxt_c;
                stub_y    <= nxt_s;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: the result vector (c + j*s) rotated by q quarter turns.
    function automatic void ref_fold(input int q, input logic [31:0] c, input logic [31:0] s,
                                     output logic [32:0] ec, output logic [32:0] es);
        longint x, y, t;
        x = longint'(c);
        y = longint'(s);
        for (int i = 0; i < q; i++) begin
            t = x; x = -y; y = t;
        end
        ec = x[32:0];
        es = y[32:0];
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic send(input logic [1:0] q, input logic [31:0] r);
        bit ok = 0;
        in_angle = {q, r};
        in_valid = 1'b1;
        #1;
        for (int n = 0; n < 200; n++) begin
            if (in_ready) begin ok = 1; break; end
            @(negedge clk); #1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_out();
        bit ok = 0;
        for (int n = 0; n < 100; n++) begin
            if (out_valid) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk("out_timeout", 0, 1);
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_res(input string tag, input int q, input logic [31:0] c, input logic [31:0] s);
        logic [32:0] ec, es;
        ref_fold(q, c, s, ec, es);
        chk({tag, "_cos"}, out_cos, ec);
        chk({tag, "_sin"}, out_sin, es);
    endtask

    task automatic txn(input string tag, input logic [1:0] q, input logic [31:0] r,
                       input logic [31:0] c, input logic [31:0] s, input int hold);
        int s0;
        nxt_c = c; nxt_s = s;
        s0 = start_cnt;
        send(q, r);
        chk({tag, "_angle"}, core_angle, r);
        wait_out();
        check_res(tag, q, c, s);
        repeat (hold) @(negedge clk);
        chk({tag, "_hold_cos"}, out_valid, 1);
        chk({tag, "_starts"}, start_cnt - s0, 1);
        pop();
    endtask

    initial begin
        logic [32:0] ec, es;
        int s0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cos", out_cos, 0);
        chk("rst_sin", out_sin, 0);
        chk("rst_start", core_start, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // Directed first transaction
        nxt_c = 32'h1234; nxt_s = 32'h5678;
        s0 = start_cnt;
        send(2'b00, 32'h4000_0000);
        chk("t0_angle", core_angle, 32'h4000_0000);
        chk("t0_core_x", core_x, KVAL);
        chk("t0_core_y", core_y, 0);
        chk("t0_mode", core_mode, 0);
        wait_out();
        chk("t0_cos", out_cos, 33'h0_0000_1234);
        chk("t0_sin", out_sin, 33'h0_0000_5678);
        chk("t0_starts", start_cnt - s0, 1);
        pop();
        chk("t0_idle", out_valid, 0);

        // Quadrants 2 and 1 with fixed stub values
        nxt_c = 32'h1234; nxt_s = 32'h5678;
        send(2'b10, 32'h1000_0000);
        wait_out();
        chk("q2_cos", out_cos, 33'h1_FFFF_EDCC);
        chk("q2_sin", out_sin, 33'h1_FFFF_A988);
        pop();
        send(2'b01, 32'h2000_0000);
        wait_out();
        chk("q1_cos", out_cos, 33'h1_FFFF_A988);
        chk("q1_sin", out_sin, 33'h0_0000_1234);

        // Hold in OUT for 10 cycles, then back-to-back accept
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_cos", out_cos, 33'h1_FFFF_A988);
            chk("hold_sin", out_sin, 33'h0_0000_1234);
        end
        nxt_c = 32'hABCD; nxt_s = 32'h0001;
        in_angle = {2'b11, 32'h0300_0000};
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("b2b_start_now", core_start, 1);
        chk("b2b_angle", core_angle, 32'h0300_0000);
        wait_out();
        check_res("b2b", 3, 32'hABCD, 32'h0001);
        pop();

        // core_ready low for 4 cycles with a stale done level before launch
        ready_block = 1'b1; done_force = 1'b1;
        nxt_c = 32'h0F0F; nxt_s = 32'h7070;
        s0 = start_cnt;
        send(2'b01, 32'h0555_0000);
        for (int i = 0; i < 4; i++) begin
            chk("stall_start", core_start, 0);
            chk("stall_valid", out_valid, 0);
            @(negedge clk);
        end
        ready_block = 1'b0;
        #1;
        chk("stall_release_start", core_start, 1);
        @(posedge clk); #1;
        done_force = 1'b0;
        @(negedge clk);
        chk("stall_no_early", out_valid, 0);
        wait_out();
        check_res("stall", 1, 32'h0F0F, 32'h7070);
        chk("stall_starts", start_cnt - s0, 1);
        pop();

        // Reset while waiting on the core
        nxt_c = 32'h2222; nxt_s = 32'h3333;
        send(2'b10, 32'h0777_0000);
        for (int n = 0; n < 50 && stub_cnt != 3; n++) @(negedge clk);
        chk("mid_reach_wait", stub_cnt, 3);
        reset = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_cos", out_cos, 0);
        chk("mid_rst_sin", out_sin, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_idle", in_ready, 1);
        repeat (8) @(negedge clk);
        chk("mid_rst_no_ghost", out_valid, 0);
        txn("after_rst", 2'b00, 32'h1111_0000, 32'h4444, 32'h5555, 0);

`ifdef CORDIC_QUAD_AXIS_BYPASS_EN
        for (int q = 0; q < 4; q++) begin
            s0 = start_cnt;
            send(q[1:0], 32'h0);
            chk("byp_valid", out_valid, 1);
            ref_fold(q, 32'hFFFF_FFFF, 32'h0, ec, es);
            chk("byp_cos", out_cos, ec);
            chk("byp_sin", out_sin, es);
            chk("byp_no_start", start_cnt - s0, 0);
            pop();
        end
`else
        txn("zero_resid", 2'b11, 32'h0, 32'h8000_0000, 32'h0000_0003, 1);
`endif

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            txn("rnd", 2'($urandom_range(0, 3)), $urandom | 32'h1, $urandom, $urandom,
                $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
